// File: rtl/systolic_output_collector.sv
// systolic_output_collector
// De-skews the staggered column outputs of a 4x4 systolic array into whole
// rows and queues them in a 4-entry show-ahead FIFO.
// Optional feature: define COLLECTOR_ROW_SUM_EN to add the row_sum output.
module systolic_output_collector #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] in_col [0:3],
    output logic signed [WIDTH-1:0] out_row [0:3],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    overflow,
    output logic [2:0]              fifo_count
`ifdef COLLECTOR_ROW_SUM_EN
    ,
    output logic signed [WIDTH+1:0] row_sum
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    // LATENCY=1 skips WAIT entirely, so the load value is only used for LATENCY>1
    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Column j is delayed by 3-j registers; column 3 feeds the row directly
    logic signed [WIDTH-1:0] dl0_q [0:2];
    logic signed [WIDTH-1:0] dl0_d [0:2];
    logic signed [WIDTH-1:0] dl1_q [0:1];
    logic signed [WIDTH-1:0] dl1_d [0:1];
    logic signed [WIDTH-1:0] dl2_q, dl2_d;

    logic signed [WIDTH-1:0] mem_q [0:3][0:3];
    logic signed [WIDTH-1:0] mem_d [0:3][0:3];
    logic [1:0]              wr_ptr_q, wr_ptr_d;
    logic [1:0]              rd_ptr_q, rd_ptr_d;
    logic [2:0]              count_q, count_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] out_row_q [0:3];
    logic signed [WIDTH-1:0] out_row_d [0:3];
    logic                    overflow_q, overflow_d;

    logic                    push;
    logic                    overflow_clr;
    logic signed [WIDTH-1:0] push_row [0:3];

    // Pass sequencing: wait out the array latency, then capture and align seven beats
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        overflow_clr = 1'b0;
        push         = 1'b0;
        dl0_d        = dl0_q;
        dl1_d        = dl1_q;
        dl2_d        = dl2_q;
        push_row[0]  = dl0_q[2];
        push_row[1]  = dl1_q[1];
        push_row[2]  = dl2_q;
        push_row[3]  = in_col[3];
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    overflow_clr = 1'b1;
                    if (WAIT_LOAD == 4'd0) begin
                        state_d = S_CAPTURE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                dl0_d[0] = in_col[0];
                dl0_d[1] = dl0_q[0];
                dl0_d[2] = dl0_q[1];
                dl1_d[0] = in_col[1];
                dl1_d[1] = dl1_q[0];
                dl2_d    = in_col[2];
                push     = (cnt_q >= 4'd3);
                if (cnt_q == 4'd6) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    logic pop;
    logic full;
    logic do_push;
    logic drop;

    // FIFO bookkeeping; the head register is refreshed from next-state memory so it
    // reflects a same-edge push/pop and holds its last value once the FIFO drains
    always_comb begin
        pop      = out_valid_q && out_ready;
        full     = (count_q == 3'd4);
        do_push  = push && (!full || pop);
        drop     = push && full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            for (int unsigned j = 0; j < 4; j++) begin
                mem_d[wr_ptr_q][j] = push_row[j];
            end
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d     = count_q + {2'b00, do_push} - {2'b00, pop};
        out_valid_d = (count_d != 3'd0);
        overflow_d  = overflow_clr ? 1'b0 : (overflow_q | drop);
        out_row_d   = out_row_q;
        if (count_d != 3'd0) begin
            for (int unsigned j = 0; j < 4; j++) begin
                out_row_d[j] = mem_d[rd_ptr_d][j];
            end
        end
    end

    // State, delay line and FIFO registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dl2_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) dl0_q[i] <= '0;
            for (int unsigned i = 0; i < 2; i++) dl1_q[i] <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                out_row_q[i] <= '0;
                for (int unsigned j = 0; j < 4; j++) mem_q[i][j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dl0_q       <= dl0_d;
            dl1_q       <= dl1_d;
            dl2_q       <= dl2_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_row    = out_row_q;
    assign out_valid  = out_valid_q;
    assign busy       = (state_q != S_IDLE);
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

`ifdef COLLECTOR_ROW_SUM_EN
    logic signed [WIDTH+1:0] row_sum_q, row_sum_d;

    // Sign-extended sum of the next head row, registered alongside out_row
    always_comb begin
        row_sum_d = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            row_sum_d = row_sum_d + {{2{out_row_d[j][WIDTH-1]}}, out_row_d[j]};
        end
    end

    // Row sum register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_sum_q <= '0;
        end else begin
            row_sum_q <= row_sum_d;
        end
    end

    assign row_sum = row_sum_q;
`endif

endmodule

// File: tb/tb_systolic_output_collector.sv
// Directed bench for systolic_output_collector (LATENCY=4, WIDTH=16).
// Row-sum checks are compiled in when COLLECTOR_ROW_SUM_EN is defined.
module tb_systolic_output_collector;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic signed [15:0] in_col [0:3];
    logic signed [15:0] out_row [0:3];
    logic out_valid;
    logic out_ready;
    logic busy;
    logic overflow;
    logic [2:0] fifo_count;
`ifdef COLLECTOR_ROW_SUM_EN
    logic signed [17:0] row_sum;
`endif

    int errors = 0;
    int checks = 0;

    logic signed [15:0] rows_exp [0:3][0:3];

    systolic_output_collector #(
        .WIDTH(16),
        .LATENCY(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_col(in_col),
        .out_row(out_row),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .overflow(overflow),
        .fifo_count(fifo_count)
`ifdef COLLECTOR_ROW_SUM_EN
        ,
        .row_sum(row_sum)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input int r);
        logic signed [31:0] sum;
        sum = 0;
        chk({tag, "_valid"}, out_valid, 1);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("%s_r%0d_c%0d", tag, r, j), out_row[j], rows_exp[r][j]);
            sum = sum + rows_exp[r][j];
        end
`ifdef COLLECTOR_ROW_SUM_EN
        chk($sformatf("%s_sum_r%0d", tag, r), row_sum, sum);
`endif
    endtask

    task automatic load_std(input int base);
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                rows_exp[r][j] = 16'(base + 10 * r + j);
    endtask

    task automatic zero_cols();
        for (int j = 0; j < 4; j++) in_col[j] = '0;
    endtask

    // One skewed pass: start at E0, column j carries row r at edge E0+4+r+j.
    task automatic run_pass(input bit inline_chk, input int abort_k, input bit restart);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int w = 1; w <= 3; w++) begin
            start = (restart && w == 2);
            tick();
            start = 1'b0;
        end
        for (int k = 0; k <= 6; k++) begin
            if (k == abort_k) rst = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (k - j >= 0 && k - j <= 3) in_col[j] = rows_exp[k - j][j];
                else in_col[j] = '0;
            end
            tick();
            if (k == abort_k) begin
                rst = 1'b1;
                zero_cols();
                return;
            end
            if (inline_chk && k >= 3) chk_row($sformatf("inline_k%0d", k), k - 3);
        end
        zero_cols();
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        zero_cols();
        load_std(0);

        // Reset, with a start pulse coinciding with reset
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_row0", out_row[0], 0);
        chk("rst_row3", out_row[3], 0);
        rst = 1'b1;
        tick();
        chk("start_in_rst_ignored", busy, 0);

        // Basic pass, consumer always ready
        out_ready = 1'b1;
        run_pass(1'b1, -1, 1'b0);
        chk("basic_idle", busy, 0);
        tick();
        chk("basic_drained_valid", out_valid, 0);
        chk("basic_drained_count", fifo_count, 0);
        chk("basic_hold_r3c0", out_row[0], 30);
        chk("basic_hold_r3c3", out_row[3], 33);

        // Backpressure until full
        out_ready = 1'b0;
        run_pass(1'b0, -1, 1'b0);
        chk("bp_count", fifo_count, 4);
        chk("bp_ovf", overflow, 0);
        chk_row("bp_stall_a", 0);
        tick();
        tick();
        chk_row("bp_stall_b", 0);
        chk("bp_count_b", fifo_count, 4);
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            chk_row("bp_drain", r);
            tick();
        end
        chk("bp_empty_valid", out_valid, 0);
        chk("bp_empty_count", fifo_count, 0);

        // Overflow: two back-to-back passes, consumer never ready
        out_ready = 1'b0;
        run_pass(1'b0, -1, 1'b0);
        load_std(100);
        run_pass(1'b0, -1, 1'b0);
        load_std(0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", fifo_count, 4);
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            chk_row("ovf_drain", r);
            tick();
        end
        chk("ovf_empty_valid", out_valid, 0);
        chk("ovf_sticky", overflow, 1);

        // Reset at k=4 of a pass
        out_ready = 1'b0;
        run_pass(1'b0, 4, 1'b0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_count", fifo_count, 0);
        chk("abort_ovf", overflow, 0);
        chk("abort_row3", out_row[3], 0);
        out_ready = 1'b1;
        run_pass(1'b1, -1, 1'b0);
        tick();
        chk("post_abort_empty", out_valid, 0);

        // Second start at E0+2 is ignored
        out_ready = 1'b1;
        run_pass(1'b1, -1, 1'b1);
        chk("restart_idle", busy, 0);
        tick();
        chk("restart_empty", out_valid, 0);
        chk("restart_count", fifo_count, 0);
        tick();
        tick();
        chk("restart_still_idle", busy, 0);
        chk("restart_no_extra", out_valid, 0);

        // Signed values
        rows_exp[0][0] = -16'sd5;    rows_exp[0][1] = -16'sd6;
        rows_exp[0][2] = 16'sd7;     rows_exp[0][3] = -16'sd8;
        rows_exp[1][0] = 16'sd1;     rows_exp[1][1] = -16'sd2;
        rows_exp[1][2] = 16'sd3;     rows_exp[1][3] = -16'sd4;
        rows_exp[2][0] = -16'sd100;  rows_exp[2][1] = 16'sd200;
        rows_exp[2][2] = -16'sd300;  rows_exp[2][3] = 16'sd400;
        rows_exp[3][0] = 16'sd32767; rows_exp[3][1] = -16'sd32768;
        rows_exp[3][2] = 16'sd0;     rows_exp[3][3] = -16'sd1;
        out_ready = 1'b0;
        run_pass(1'b0, -1, 1'b0);
        chk("signed_c0", out_row[0], -5);
        chk("signed_c3", out_row[3], -8);
`ifdef COLLECTOR_ROW_SUM_EN
        chk("signed_sum", row_sum, -12);
`endif
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            chk_row("signed_drain", r);
            tick();
        end
        chk("signed_empty", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
